// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 64-bit memory port between IFU and LSU, one transaction at a time.
// LSU wins by default; after STARVE_LIMIT consecutive IFU losses the IFU gets the next grant.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [31:0] if_addr,
   output logic        if_resp_valid,
   output logic [31:0] if_resp_data,
   input  logic        ls_req_valid,
   output logic        ls_req_ready,
   input  logic [31:0] ls_addr,
   input  logic        ls_wen,
   input  logic [63:0] ls_wdata,
   input  logic [7:0]  ls_wmask,
   output logic        ls_resp_valid,
   output logic [63:0] ls_resp_data,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_resp_data
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   state_t      r_state, w_next;
   logic        w_grant_if, w_grant_ls;
   logic        r_owner_if, r_hi, r_wen, r_if_rv, r_ls_rv;
   logic [3:0]  r_starve;
   logic [31:0] r_addr;
   logic [63:0] r_wdata, r_data;
   logic [7:0]  r_wmask;
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else r_state <= w_next;
   end
   // Grants are only ever issued from IDLE and never while reset is asserted.
   always_comb begin
      w_next = r_state;
      w_grant_if = 1'b0;
      w_grant_ls = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_grant_if = rst && if_req_valid && (!ls_req_valid || r_starve == LIMIT);
            w_grant_ls = rst && ls_req_valid && !w_grant_if;
            w_next = (w_grant_if || w_grant_ls) ? S_REQ : S_IDLE;
         end
         S_REQ:   w_next = mem_req_ready ? S_WAIT : S_REQ;
         S_WAIT:  w_next = mem_resp_valid ? S_IDLE : S_WAIT;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_owner_if <= 1'b0;
         r_hi       <= 1'b0;
         r_addr     <= '0;
         r_wen      <= 1'b0;
         r_wdata    <= '0;
         r_wmask    <= '0;
         r_starve   <= '0;
         r_data     <= '0;
         r_if_rv    <= 1'b0;
         r_ls_rv    <= 1'b0;
      end else begin
         r_if_rv <= 1'b0;
         r_ls_rv <= 1'b0;
         if (w_grant_if || w_grant_ls) begin
            r_owner_if <= w_grant_if;
            r_addr     <= (w_grant_if ? if_addr : ls_addr) & 32'hFFFF_FFF8;
            r_hi       <= w_grant_if ? if_addr[2] : ls_addr[2];
            r_wen      <= w_grant_ls && ls_wen;
            r_wdata    <= w_grant_ls ? ls_wdata : '0;
            r_wmask    <= w_grant_ls ? ls_wmask : '0;
         end
         if (w_grant_if) r_starve <= '0;
         else if (w_grant_ls && if_req_valid && r_starve != LIMIT) r_starve <= r_starve + 4'd1;
         if (r_state == S_WAIT && mem_resp_valid) begin
            r_data  <= mem_resp_data;
            r_if_rv <= r_owner_if;
            r_ls_rv <= !r_owner_if;
         end
      end
   end
   assign if_req_ready  = w_grant_if;
   assign ls_req_ready  = w_grant_ls;
   assign mem_req_valid = r_state == S_REQ;
   assign mem_addr      = r_addr;
   assign mem_wen       = r_wen;
   assign mem_wdata     = r_wdata;
   assign mem_wmask     = r_wmask;
   assign if_resp_valid = r_if_rv;
   assign if_resp_data  = r_hi ? r_data[63:32] : r_data[31:0];
   assign ls_resp_valid = r_ls_rv;
   assign ls_resp_data  = r_data;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single 64-bit physical memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It runs one memory transaction at a time with a request/ready handshake toward the memory side and returns each response only to the requester that issued it. LSU requests win by default; a starvation counter guarantees forward progress for fetch. It sits between IFU/LSU and the memory model/bus.

## Interface
- STARVE_LIMIT, 4, consecutive IFU losses after which IFU gets priority for the next grant (1..15)
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-low
- if_req_valid  in  1  IFU fetch request
- if_req_ready  out  1  IFU request accepted this cycle
- if_addr  in  32  fetch address (4-byte aligned)
- if_resp_valid  out  1  one-cycle pulse, fetch data valid
- if_resp_data  out  32  instruction word
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  LSU request accepted this cycle
- ls_addr  in  32  LSU address
- ls_wen  in  1  1 = write, 0 = read
- ls_wdata  in  64  write data (lane-aligned)
- ls_wmask  in  8  byte enables
- ls_resp_valid  out  1  one-cycle pulse, read data / write ack
- ls_resp_data  out  64  read data (write ack: don't care)
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  8-byte-aligned address
- mem_wen  out  1  write enable
- mem_wdata  out  64  write data
- mem_wmask  out  8  byte enables
- mem_resp_valid  in  1  memory response (reads and writes)
- mem_resp_data  in  64  read data

## Operation
- FSM: IDLE, REQ, WAIT. One transaction outstanding at most.
- IDLE: grant computed combinationally. Default LSU if ls_req_valid; IFU if only if_req_valid. If starve_cnt == STARVE_LIMIT and both valid, grant IFU.
- Grant: granted side's req_ready = 1 (all other req_ready = 0 in every state). Latch owner, mem_addr = addr & 32'hFFFF_FFF8, addr[2], wen/wdata/wmask (IFU: wen=0, wmask=0). Go to REQ.
- starve_cnt (4 bits): +1 when both valid and LSU granted; cleared when IFU granted; saturates at STARVE_LIMIT.
- REQ: mem_req_valid = 1, mem_* held stable. mem_req_ready -> WAIT.
- WAIT: mem_req_valid = 0. mem_resp_valid -> capture data, go to IDLE, set owner's resp_valid register.
- if_resp_data = latched addr[2] ? data[63:32] : data[31:0]. ls_resp_data = full 64 bits.
- mem_resp_valid outside WAIT is ignored.
- Requesters hold req_valid/payload until req_ready; arbiter does not buffer a second request.

## Timing
- Reset (rst = 0 at posedge): state IDLE, starve_cnt 0, mem_req_valid 0, if_resp_valid 0, ls_resp_valid 0, resp data 0, mem_addr/wen/wdata/wmask 0. req_ready outputs 0 while rst = 0.
- Reset mid-transaction: in-flight transaction abandoned, no response pulse, late mem_resp_valid ignored.
- Cycle 0: grant (req_ready = 1). Cycle 1: mem_req_valid = 1. Min. 1 cycle in REQ. WAIT holds until mem_resp_valid at cycle N. Resp_valid pulse at N+1, exactly one cycle.
- Back-to-back: cycle N+1 is IDLE, so a new grant can coincide with the previous resp_valid pulse. Minimum 3 cycles per transaction when mem_req_ready and mem_resp_valid arrive immediately.
- mem_req_ready and mem_resp_valid in the same cycle (REQ state): only the handshake counts; the response is taken in WAIT.
- resp_valid has no backpressure; requesters must sink it.

## Test plan
- IFU only, if_addr 0x8000_0004, mem returns 0x1111_2222_3333_4444 one cycle after ready -> mem_addr 0x8000_0000, if_resp_data 0x1111_2222, one-cycle pulse 3 cycles after grant.
- Simultaneous requests, ls_addr 0x8000_0100 write, wmask 0x0F -> LSU granted first, mem_wen 1, ls_resp_valid pulse. IFU granted next transaction, no if_resp_valid for the LSU transaction.
- LSU valid every cycle, IFU valid, STARVE_LIMIT 4 -> 4 LSU grants, then IFU grant, starve_cnt back to 0.
- mem_req_ready low 5 cycles -> mem_req_valid and mem_addr held stable, single handshake, no duplicate request.
- rst low during WAIT, then mem_resp_valid -> no resp pulse, state IDLE, a new IFU request is granted normally afterward.
- Spurious mem_resp_valid in IDLE -> no resp_valid on either side.
